// File: rtl/method_test_pkg.sv
// Shared types and helpers for the method test sequencer.
// Holds the run state encoding and the cur_ch width helper.
package method_test_pkg;

    // Run states of the sequencer.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE    = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_GRACE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_NEXT   = 3'd5,
        ST_FINISH = 3'd6
    } state_e;

    // Width of the cur_ch index.
    // A single-channel build still gets a 1-bit port.
    function automatic int cur_ch_w(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/method_channel_checker.sv
// Per-channel request/compare slice of the method test sequencer.
// Ports: clk, reset (async active-low), clear_i (new run), issue_i
// (raise req), abort_i (timeout), grace_done_i (busy trusted),
// busy_i, ret_i, exp_i; outputs req_o, done_o, comp_o (completion
// this cycle), fail_o (return mismatch), tmo_o (not done at timeout).
module method_channel_checker
    import method_test_pkg::*;
#(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             issue_i,
    input  logic             abort_i,
    input  logic             grace_done_i,
    input  logic             busy_i,
    input  logic [RET_W-1:0] ret_i,
    input  logic [RET_W-1:0] exp_i,
    output logic             req_o,
    output logic             done_o,
    output logic             comp_o,
    output logic             fail_o,
    output logic             tmo_o
);

    logic req_q, req_d;
    logic done_q, done_d;
    logic fail_q, fail_d;
    logic tmo_q, tmo_d;

    // A completion is only honoured once busy is trusted, and a
    // timeout in the same cycle wins over it.
    assign comp_o = req_q & ~busy_i & grace_done_i & ~abort_i;

    always_comb begin
        req_d  = req_q;
        done_d = done_q;
        fail_d = fail_q;
        tmo_d  = tmo_q;
        if (clear_i) begin
            req_d  = 1'b0;
            done_d = 1'b0;
            fail_d = 1'b0;
            tmo_d  = 1'b0;
        end else if (abort_i) begin
            req_d = 1'b0;
            tmo_d = ~done_q;
        end else if (comp_o) begin
            req_d  = 1'b0;
            done_d = 1'b1;
            fail_d = (ret_i != exp_i);
        end else if (issue_i) begin
            req_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            fail_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            req_q  <= req_d;
            done_q <= done_d;
            fail_q <= fail_d;
            tmo_q  <= tmo_d;
        end
    end

    assign req_o  = req_q;
    assign done_o = done_q;
    assign fail_o = fail_q;
    assign tmo_o  = tmo_q;

endmodule

// File: rtl/method_test_sequencer.sv
// Self-checking sequencer driving req/busy/return method blocks.
// Ports: clk, reset (async active-low), start, dut_reset, ch_req,
// ch_busy, ch_return, ch_expect, done, pass, fail_mask,
// timeout_mask, cur_ch.
module method_test_sequencer
    import method_test_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int RET_W     = 32,
    parameter int RST_START = 3,
    parameter int RST_END   = 8,
    parameter int REQ_DELAY = 100,
    parameter int GRACE     = 5,
    parameter int TIMEOUT   = 10000,
    parameter int PARALLEL  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      dut_reset,
    output logic [NUM_CH-1:0]         ch_req,
    input  logic [NUM_CH-1:0]         ch_busy,
    input  logic [NUM_CH*RET_W-1:0]   ch_return,
    input  logic [NUM_CH*RET_W-1:0]   ch_expect,
    output logic                      done,
    output logic                      pass,
    output logic [NUM_CH-1:0]         fail_mask,
    output logic [NUM_CH-1:0]         timeout_mask,
    output logic [cur_ch_w(NUM_CH)-1:0] cur_ch
);

    localparam int CW = cur_ch_w(NUM_CH);
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
    localparam logic [31:0] C_TMO   = 32'(TIMEOUT);
    localparam logic [31:0] C_RSTS  = 32'(RST_START);
    localparam logic [31:0] C_RSTE  = 32'(RST_END);
    localparam logic [31:0] C_PRE   = 32'(REQ_DELAY - 1);
    localparam logic [31:0] C_GRACE = 32'(GRACE);

    state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] grace_q, grace_d;
    logic [CW-1:0] cur_q, cur_d;
    logic rst_q, rst_d;

    logic active;
    logic start_ok;
    logic tmo_hit;
    logic clear;
    logic abort;
    logic grace_done;
    logic set_done;
    logic [NUM_CH-1:0] issue_vec;
    logic [NUM_CH-1:0] comp_vec;
    logic [NUM_CH-1:0] done_vec;
    logic [NUM_CH-1:0] done_now;

    assign active = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign start_ok = start && !active;
    assign tmo_hit = active && (cnt_q == C_TMO);
    assign grace_done = (state_q == ST_WAIT);

    // Completions seen this cycle count toward leaving WAIT, so the
    // FSM moves on in step with the req drop.
    assign done_now = done_vec | comp_vec;

    always_comb begin
        if (PARALLEL != 0) begin
            set_done = &done_now;
        end else begin
            set_done = done_now[cur_q];
        end
    end

    // Run counter and registered DUT reset window.
    always_comb begin
        cnt_d = cnt_q;
        if (start_ok) begin
            cnt_d = '0;
        end else if (active) begin
            cnt_d = cnt_q + 32'd1;
        end
        rst_d = active && (cnt_q >= C_RSTS) && (cnt_q <= C_RSTE);
    end

    // Next-state logic. PRE leaves one cycle early so that req is
    // already high on the cycle the counter reads REQ_DELAY.
    always_comb begin
        state_d   = state_q;
        grace_d   = grace_q;
        cur_d     = cur_q;
        clear     = 1'b0;
        abort     = 1'b0;
        issue_vec = '0;
        unique case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    state_d = ST_PRE;
                    clear   = 1'b1;
                    cur_d   = '0;
                end
            end
            ST_PRE: begin
                if (cnt_q == C_PRE) begin
                    state_d = ST_ISSUE;
                    if (PARALLEL != 0) begin
                        issue_vec = '1;
                    end else begin
                        issue_vec = NUM_CH'(1) << cur_q;
                    end
                end
            end
            ST_ISSUE: begin
                grace_d = C_GRACE;
                if (GRACE == 0) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_GRACE;
                end
            end
            ST_GRACE: begin
                grace_d = grace_q - 32'd1;
                if (grace_q <= 32'd1) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (set_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if ((PARALLEL != 0) || (cur_q == LAST_CH)) begin
                    state_d = ST_FINISH;
                end else begin
                    cur_d     = cur_q + CW'(1);
                    issue_vec = NUM_CH'(1) << cur_d;
                    state_d   = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Timeout overrides whatever the state wanted this cycle.
        if (tmo_hit) begin
            state_d   = ST_FINISH;
            abort     = 1'b1;
            issue_vec = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            grace_q <= '0;
            cur_q   <= '0;
            rst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grace_q <= grace_d;
            cur_q   <= cur_d;
            rst_q   <= rst_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        method_channel_checker #(
            .RET_W(RET_W)
        ) u_chk (
            .clk         (clk),
            .reset       (reset),
            .clear_i     (clear),
            .issue_i     (issue_vec[i]),
            .abort_i     (abort),
            .grace_done_i(grace_done),
            .busy_i      (ch_busy[i]),
            .ret_i       (ch_return[i*RET_W +: RET_W]),
            .exp_i       (ch_expect[i*RET_W +: RET_W]),
            .req_o       (ch_req[i]),
            .done_o      (done_vec[i]),
            .comp_o      (comp_vec[i]),
            .fail_o      (fail_mask[i]),
            .tmo_o       (timeout_mask[i])
        );
    end

    assign dut_reset = rst_q;
    assign done      = (state_q == ST_FINISH);
    assign pass      = done && (fail_mask == '0) && (timeout_mask == '0);
    assign cur_ch    = cur_q;

endmodule

// File: doc/method_test_sequencer.md
Name: method_test_sequencer

Overview:
- Synthesizable self-checking sequencer for generated method blocks that use the req/busy/return handshake.
- Generates the DUT reset pulse and issues method requests on NUM_CH channels, either one after another or all at once.
- Checks each channel's return value against an expected value and enforces a global cycle timeout.
- Reports pass/fail per channel and overall. Used in simulation top-levels and in FPGA smoke tests.

Parameters:
- NUM_CH, 4, number of method channels (1..16)
- RET_W, 32, width of each return/expect word (1..64)
- RST_START, 3, first cycle after start at which dut_reset is asserted
- RST_END, 8, last cycle at which dut_reset is asserted (RST_END >= RST_START)
- REQ_DELAY, 100, cycle after start at which the first request may be issued (> RST_END)
- GRACE, 5, cycles after req rises before busy is trusted
- TIMEOUT, 10000, global cycle limit measured from start
- PARALLEL, 0, 0 = channels run sequentially in index order; 1 = all channels run together

Ports:
- clk, in, 1, system clock
- reset, in, 1, asynchronous, active-low reset
- start, in, 1, one-cycle pulse that begins a run; ignored unless in IDLE or FINISH
- dut_reset, out, 1, active-high reset to the DUT
- ch_req, out, NUM_CH, method request per channel; level, held until the channel completes
- ch_busy, in, NUM_CH, method busy per channel
- ch_return, in, NUM_CH*RET_W, return values; channel i at [i*RET_W +: RET_W]
- ch_expect, in, NUM_CH*RET_W, expected values; must be stable while a run is active
- done, out, 1, high from FINISH entry until the next start
- pass, out, 1, valid while done: no failures and no timeout
- fail_mask, out, NUM_CH, per-channel return mismatch
- timeout_mask, out, NUM_CH, channels not yet complete when TIMEOUT was hit
- cur_ch, out, clog2(NUM_CH) (minimum 1), channel currently active in sequential mode; 0 in parallel mode

Behaviour:
- Reset (reset low): every output is 0, cycle counter is 0, state is IDLE. Asserting reset mid-run aborts the run immediately and leaves no residual req.
- Cycle counter: 32 bits; cleared on start; increments every cycle while the run is active (states after IDLE, before FINISH).
- dut_reset: high exactly when RST_START <= counter <= RST_END. It is a registered output, so it changes one cycle after the counter reaches the boundary.
- States:
  - IDLE: wait for start.
  - PRE: wait until counter = REQ_DELAY.
  - ISSUE: raise req for the active set (one channel when PARALLEL=0, all channels when PARALLEL=1). Load the grace counter with GRACE.
  - GRACE: count down; busy is ignored. At 0, go to WAIT.
  - WAIT: a channel completes when its req is high and its busy is low. On completion, sample its return the same cycle, compare with expect, set fail_mask[i] on mismatch, and drop req[i] the next cycle. Leave WAIT when the whole active set is complete.
  - NEXT: in sequential mode, increment cur_ch and go to ISSUE, or go to FINISH after the last channel. In parallel mode, go straight to FINISH.
  - FINISH: done=1; pass = (fail_mask==0 && timeout_mask==0); all req low. Stays here until start, which clears the masks, done and pass and re-enters PRE.
- Timeout: from any active state, counter = TIMEOUT forces FINISH. timeout_mask is set for every channel whose completion has not been recorded, including channels never issued. In the same cycle it takes priority over a completion.
- Simultaneous completions in parallel mode are all recorded in one cycle.
- A busy deassertion during GRACE is not a completion. A DUT that is never busy completes on the first WAIT cycle.
- start received while active is ignored.

Decomposition:
- Package method_test_pkg: state enum (IDLE, PRE, ISSUE, GRACE, WAIT, NEXT, FINISH) and the function computing cur_ch width.
- Sub-module method_channel_checker: one instance per channel. Holds req, the completion flag, the compare logic and the fail bit. Inputs: issue, abort, busy, return, expect, grace_done.

Test Plan:
- NUM_CH=1, PARALLEL=0; model busy for 20 cycles after req and return 1 with expect 1. Required: dut_reset high on counter 3..8 (output cycles 4..9); req at cycle 100; done=1, pass=1, fail_mask=0.
- NUM_CH=4, sequential; channel 2 returns 0x5 with expect 0x6. Required: requests issued strictly in order 0,1,2,3; fail_mask=4'b0100; pass=0.
- NUM_CH=4, PARALLEL=1; busy durations 10/30/30/50 cycles. Required: all reqs rise together at 100; channels 1 and 2 are recorded in the same cycle; done follows the last channel's completion.
- TIMEOUT=300; channel 1 never drops busy. Required: FINISH at counter 300; timeout_mask=4'b1110 in sequential mode; all reqs low; pass=0.
- DUT never raises busy, GRACE=5. Required: completion recorded on the first WAIT cycle (req + 6); no spurious completion during GRACE.
- Pull reset low during WAIT, release it, then pulse start. Required: outputs zero during reset; the fresh run behaves identically to the first scenario.
